// File: rtl/fetch_unit.sv
// Instruction prefetch unit: keeps a small FIFO of fetched instructions ahead of
// the decoder, with one outstanding memory request, branch flush and sticky halt.
module fetch_unit #(
    parameter int AW = 16,
    parameter int IW = 16,
    parameter int DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic          dec_valid,
    output logic [IW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc,
    input  logic          dec_ready,
    input  logic          br_valid,
    input  logic [2:0]    br_cond,
    input  logic [2:0]    br_flags,
    input  logic [AW-1:0] br_target,
    output logic          hlt,
    output logic [AW-1:0] pc
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [IW-1:0] buf_instr [DEPTH];
    logic [AW-1:0] buf_pc    [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count, count_next;
    logic          req, discard, hlt_q, halt_pend;
    logic [AW-1:0] pc_q, addr_q;

    logic cond_true, taken, pop, push, hold, issue, hlt_pop;
    logic hlt_next, pend_next, req_next, discard_next;
    logic [AW-1:0] pc_next, addr_next;

    // Flags are ordered {Z,V,N}.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b000: cond_true = !br_flags[2];
            3'b001: cond_true = br_flags[2];
            3'b010: cond_true = !br_flags[2] && !br_flags[0];
            3'b011: cond_true = br_flags[0];
            3'b100: cond_true = br_flags[2] || (!br_flags[2] && !br_flags[0]);
            3'b101: cond_true = br_flags[2] || br_flags[0];
            3'b110: cond_true = br_flags[1];
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        taken     = br_valid && cond_true && !hlt_q;
        dec_valid = (count != '0) && !hlt_q;
        pop       = dec_valid && dec_ready;
        push      = req && imem_ack && !discard && !taken && !hlt_q;
        hlt_pop   = pop && (buf_instr[head][IW-1 -: 4] == 4'hF);
        hlt_next  = hlt_q || (hlt_pop && !taken);
        // An HLT sitting in the buffer stops prefetch; a flush removes it.
        pend_next = taken ? 1'b0
                  : (halt_pend || (push && (imem_data[IW-1 -: 4] == 4'hF)));
        count_next = taken ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
        pc_next = taken ? {br_target[AW-1:1], 1'b0}
                : push  ? pc_q + AW'(2)
                : pc_q;
        hold  = req && !imem_ack;
        issue = !hold && !hlt_next && !pend_next && (count_next < FULL);
        req_next  = hold || issue;
        addr_next = hold ? addr_q : pc_next;
        // A request held across a flush or halt returns data that must be dropped.
        discard_next = hold && (discard || taken || hlt_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req       <= 1'b0;
            discard   <= 1'b0;
            hlt_q     <= 1'b0;
            halt_pend <= 1'b0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            pc_q      <= pc_next;
            addr_q    <= addr_next;
            req       <= req_next;
            discard   <= discard_next;
            hlt_q     <= hlt_next;
            halt_pend <= pend_next;
            count     <= count_next;
            if (taken) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[tail] <= imem_data;
            buf_pc[tail]    <= addr_q;
        end
    end

    assign imem_req  = req;
    assign imem_addr = addr_q;
    assign dec_instr = buf_instr[head];
    assign dec_pc    = buf_pc[head];
    assign hlt       = hlt_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, branches, halt, wrap, reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dec_ready;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [2:0]  br_flags;
    logic [15:0] br_target;
    logic        halt_en;

    logic        imem_req, dec_valid, hlt;
    logic [15:0] imem_addr, dec_instr, dec_pc, pc;
    logic        w_imem_req, w_dec_valid, w_hlt;
    logic [15:0] w_imem_addr, w_dec_instr, w_dec_pc, w_pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .br_valid(br_valid), .br_cond(br_cond), .br_flags(br_flags),
        .br_target(br_target), .hlt(hlt), .pc(pc)
    );

    fetch_unit #(.RESET_PC(16'hFFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .dec_valid(w_dec_valid),
        .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .dec_ready(dec_ready),
        .br_valid(br_valid), .br_cond(br_cond), .br_flags(br_flags),
        .br_target(br_target), .hlt(w_hlt), .pc(w_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Memory model: word 6 holds HLT when enabled, otherwise {1, addr[11:0]}.
    task automatic drive_data();
        if (halt_en && imem_addr == 16'h0006) imem_data = 16'hF000;
        else imem_data = {4'h1, imem_addr[11:0]};
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        drive_data();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dec_ready = 1'b0;
        br_valid = 1'b0;
        br_cond = 3'b000;
        br_flags = 3'b000;
        br_target = 16'h0000;
        step();
        step();
        check("rst_req", imem_req, 1'b0);
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_hlt", hlt, 1'b0);
        check("rst_pc", pc, 16'h0000);
        check("rst_w_pc", w_pc, 16'hFFFC);
        rst_n = 1'b1;
    endtask

    initial begin
        halt_en = 1'b0;
        imem_data = 16'h0000;
        do_reset();

        // Streaming
        imem_ack = 1'b1;
        dec_ready = 1'b1;
        step();
        check("s_first_req", imem_req, 1'b1);
        check("s_first_addr", imem_addr, 16'h0000);
        check("s_first_dv", dec_valid, 1'b0);
        step();
        check("s_dv", dec_valid, 1'b1);
        check("s_pc0", dec_pc, 16'h0000);
        check("s_instr0", dec_instr, 16'h1000);
        check("s_addr2", imem_addr, 16'h0002);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("s_pc_seq", dec_pc, 32'(2 * k));
            check("s_dv_seq", dec_valid, 1'b1);
        end

        // Backpressure
        do_reset();
        imem_ack = 1'b1;
        dec_ready = 1'b0;
        repeat (6) step();
        check("bp_req", imem_req, 1'b0);
        check("bp_pc", pc, 16'h0008);
        check("bp_head", dec_pc, 16'h0000);
        dec_ready = 1'b1;
        step();
        check("bp_resume_req", imem_req, 1'b1);
        check("bp_resume_addr", imem_addr, 16'h0008);
        check("bp_head2", dec_pc, 16'h0002);
        repeat (3) step();
        check("bp_head8", dec_pc, 16'h0008);

        // Branch conditions
        do_reset();
        imem_ack = 1'b1;
        dec_ready = 1'b0;
        repeat (3) step();
        check("bc_pre_dv", dec_valid, 1'b1);
        br_valid = 1'b1;
        br_cond = 3'b001;
        br_flags = 3'b100;
        br_target = 16'h0041;
        step();
        check("bc_flush_dv", dec_valid, 1'b0);
        check("bc_pc", pc, 16'h0040);
        check("bc_addr", imem_addr, 16'h0040);
        check("bc_req", imem_req, 1'b1);
        br_cond = 3'b011;
        br_flags = 3'b000;
        step();
        br_valid = 1'b0;
        check("bnt_dv", dec_valid, 1'b1);
        check("bnt_head", dec_pc, 16'h0040);
        check("bnt_addr", imem_addr, 16'h0042);

        // Branch during outstanding request
        do_reset();
        imem_ack = 1'b1;
        dec_ready = 1'b1;
        repeat (9) step();
        check("bo_addr10", imem_addr, 16'h0010);
        imem_ack = 1'b0;
        br_valid = 1'b1;
        br_cond = 3'b111;
        br_target = 16'h0081;
        step();
        br_valid = 1'b0;
        check("bo_held_req", imem_req, 1'b1);
        check("bo_held_addr", imem_addr, 16'h0010);
        check("bo_pc", pc, 16'h0080);
        check("bo_dv", dec_valid, 1'b0);
        repeat (2) step();
        check("bo_still_addr", imem_addr, 16'h0010);
        imem_ack = 1'b1;
        step();
        check("bo_disc_dv", dec_valid, 1'b0);
        check("bo_disc_pc", pc, 16'h0080);
        check("bo_new_addr", imem_addr, 16'h0080);
        step();
        check("bo_tgt_head", dec_pc, 16'h0080);
        check("bo_tgt_pc", pc, 16'h0082);

        // Halt
        halt_en = 1'b1;
        do_reset();
        imem_ack = 1'b1;
        dec_ready = 1'b1;
        repeat (5) step();
        check("h_stop_req", imem_req, 1'b0);
        check("h_head", dec_pc, 16'h0006);
        check("h_instr", dec_instr, 16'hF000);
        check("h_not_yet", hlt, 1'b0);
        step();
        check("h_hlt", hlt, 1'b1);
        check("h_dv", dec_valid, 1'b0);
        check("h_req", imem_req, 1'b0);
        repeat (2) step();
        check("h_sticky", hlt, 1'b1);
        check("h_req_later", imem_req, 1'b0);

        // Halt pop together with taken branch
        do_reset();
        imem_ack = 1'b1;
        dec_ready = 1'b1;
        repeat (5) step();
        br_valid = 1'b1;
        br_cond = 3'b111;
        br_target = 16'h0020;
        step();
        br_valid = 1'b0;
        check("hb_hlt", hlt, 1'b0);
        check("hb_req", imem_req, 1'b1);
        check("hb_addr", imem_addr, 16'h0020);
        check("hb_dv", dec_valid, 1'b0);
        halt_en = 1'b0;

        // Wrap and mid-request reset
        do_reset();
        imem_ack = 1'b1;
        dec_ready = 1'b1;
        step();
        check("w_addr0", w_imem_addr, 16'hFFFC);
        step();
        check("w_addr1", w_imem_addr, 16'hFFFE);
        check("w_head", w_dec_pc, 16'hFFFC);
        step();
        check("w_addr2", w_imem_addr, 16'h0000);
        check("w_pc", w_pc, 16'h0000);
        imem_ack = 1'b0;
        step();
        check("mr_req_pending", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_req", imem_req, 1'b0);
        check("mr_dv", dec_valid, 1'b0);
        check("mr_hlt", hlt, 1'b0);
        check("mr_pc", pc, 16'h0000);
        check("mr_w_pc", w_pc, 16'hFFFC);
        check("mr_w_req", w_imem_req, 1'b0);
        imem_ack = 1'b1;
        step();
        check("mr_ack_ignored", dec_valid, 1'b0);
        rst_n = 1'b1;
        step();
        check("mr_restart_req", imem_req, 1'b1);
        check("mr_restart_addr", imem_addr, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
